lcd_text_ctrl: RTL and testbench

LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

---
 rtl/lcd_text_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_text_ctrl : HD44780 8-bit text controller with input FIFO and cursor.
// Rev 1.0
// ----------------------------------------------------------------------------
module lcd_text_ctrl #(
  parameter int CLK_HZ     = 32768,
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam longint PWR_RAW = longint'(CLK_HZ) * 40 / 1000;
  localparam longint W5_RAW  = longint'(CLK_HZ) * 5 / 1000;
  localparam longint W1_RAW  = longint'(CLK_HZ) / 1000;
  localparam int PWR     = (PWR_RAW < 1) ? 1 : int'(PWR_RAW);
  localparam int W5      = (W5_RAW < 1) ? 1 : int'(W5_RAW);
  localparam int W1      = (W1_RAW < 1) ? 1 : int'(W1_RAW);
  localparam int WS      = 3;
  // Widened to WS as well so a tiny CLK_HZ cannot truncate the fixed setup wait.
  localparam int CNT_MAX = (PWR > WS) ? PWR : WS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int COLW    = $clog2(COLS + 1);

  localparam logic [CW-1:0] PWR_C = CW'(PWR);
  localparam logic [CW-1:0] W5_C  = CW'(W5);
  localparam logic [CW-1:0] W1_C  = CW'(W1);
  localparam logic [CW-1:0] WS_C  = CW'(WS);
  localparam logic [7:0]    FUNC  = (ROWS > 1) ? 8'h38 : 8'h30;

  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_PWR_WAIT   = 4'd1,
    ST_INIT_CMD   = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_IDLE       = 4'd4,
    ST_DISPATCH   = 4'd5,
    ST_SET_ADDR   = 4'd6,
    ST_WRITE_CHAR = 4'd7,
    ST_CLEAR      = 4'd8,
    ST_BYTE_SETUP = 4'd9,
    ST_E_HIGH     = 4'd10,
    ST_E_LOW_WAIT = 4'd11
  } state_t;

  state_t            state, ret_state;
  logic [CW-1:0]     cnt, wait_n;
  logic [2:0]        idx;
  logic [7:0]        cur;
  logic [1:0]        row;
  logic [COLW-1:0]   col;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  assign full        = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
  assign empty       = (wr_ptr == rd_ptr);
  assign push        = ascii_valid && !full;
  assign pop         = (state == ST_IDLE) && !empty;
  assign ascii_ready = !full;
  assign lcd_rw      = 1'b0;

  function automatic logic [6:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  function automatic logic [1:0] next_row(input logic [1:0] r);
    return (r == 2'(ROWS - 1)) ? 2'd0 : r + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ascii_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      ret_state <= ST_IDLE;
      cnt       <= '0;
      wait_n    <= '0;
      idx       <= '0;
      cur       <= '0;
      row       <= '0;
      col       <= '0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          cnt   <= PWR_C;
          idx   <= '0;
          lcd_e <= 1'b0;
          state <= ST_PWR_WAIT;
        end
        ST_PWR_WAIT: begin
          if (cnt == '0) state <= ST_INIT_CMD;
          else           cnt   <= cnt - 1'b1;
        end
        ST_INIT_CMD: begin
          lcd_rs <= 1'b0;
          case (idx)
            3'd0:    begin lcd_data <= 8'h30; wait_n <= W5_C; end
            3'd1,
            3'd2:    begin lcd_data <= 8'h30; wait_n <= W1_C; end
            3'd3:    begin lcd_data <= FUNC;  wait_n <= WS_C; end
            3'd4:    begin lcd_data <= 8'h0C; wait_n <= WS_C; end
            3'd5:    begin lcd_data <= 8'h06; wait_n <= WS_C; end
            default: begin lcd_data <= 8'h01; wait_n <= W5_C; end
          endcase
          ret_state <= ST_INIT_WAIT;
          state     <= ST_BYTE_SETUP;
        end
        ST_INIT_WAIT: begin
          if (idx == 3'd6) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_INIT_CMD;
          end
        end
        ST_IDLE: begin
          if (!empty) begin
            cur   <= mem[rd_ptr[AW-1:0]];
            state <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (cur >= 8'h20 && cur != 8'h7F) begin
            state <= ST_SET_ADDR;
          end else if (cur == 8'h0D) begin
            col   <= '0;
            state <= ST_IDLE;
          end else if (cur == 8'h0A) begin
            col   <= '0;
            row   <= next_row(row);
            state <= ST_IDLE;
          end else if (cur == 8'h0C) begin
            state <= ST_CLEAR;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SET_ADDR: begin
          lcd_data  <= {1'b1, row_base(row) + 7'(col)};
          lcd_rs    <= 1'b0;
          wait_n    <= WS_C;
          ret_state <= ST_WRITE_CHAR;
          state     <= ST_BYTE_SETUP;
        end
        ST_WRITE_CHAR: begin
          lcd_data  <= cur;
          lcd_rs    <= 1'b1;
          wait_n    <= WS_C;
          ret_state <= ST_IDLE;
          state     <= ST_BYTE_SETUP;
          if (col == COLW'(COLS - 1)) begin
            col <= '0;
            row <= next_row(row);
          end else begin
            col <= col + 1'b1;
          end
        end
        ST_CLEAR: begin
          lcd_data  <= 8'h01;
          lcd_rs    <= 1'b0;
          wait_n    <= W5_C;
          ret_state <= ST_IDLE;
          state     <= ST_BYTE_SETUP;
          row       <= '0;
          col       <= '0;
        end
        ST_BYTE_SETUP: begin
          lcd_e <= 1'b1;
          state <= ST_E_HIGH;
        end
        ST_E_HIGH: begin
          lcd_e <= 1'b0;
          cnt   <= wait_n;
          state <= ST_E_LOW_WAIT;
        end
        ST_E_LOW_WAIT: begin
          if (cnt == '0) state <= ret_state;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          lcd_e <= 1'b0;
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lcd_text_ctrl : scoreboard bench for lcd_text_ctrl (default parameters).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lcd_text_ctrl;

  localparam int CLK_HZ     = 32768;
  localparam int COLS       = 16;
  localparam int ROWS       = 2;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       ascii_valid = 1'b0;
  logic       ascii_ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  lcd_text_ctrl #(
    .CLK_HZ(CLK_HZ), .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .init_done(init_done), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected LCD bytes as {rs, data}
  logic [8:0] exp_q[$];
  int mrow = 0, mcol = 0;

  function automatic logic [7:0] base(input int r);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  task automatic model_char(input logic [7:0] b);
    logic [7:0] a;
    if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
    end else if (b == 8'h0C) begin
      exp_q.push_back({1'b0, 8'h01});
      mrow = 0;
      mcol = 0;
    end else if (b >= 8'h20 && b != 8'h7F) begin
      a = base(mrow) + 8'(mcol);
      exp_q.push_back({1'b0, 8'h80 | a});
      exp_q.push_back({1'b1, b});
      if (mcol == COLS - 1) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic init_expect();
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, (ROWS > 1) ? 8'h38 : 8'h30});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
    mrow = 0;
    mcol = 0;
  endtask

  // Monitor: one scoreboard pop per rising lcd_e, plus pulse-width and clear-wait tracking
  bit prev_e = 1'b0;
  bit was01  = 1'b0;
  int ehigh = 0, npulse = 0, first_cyc = 0, cyc01 = 0, clr_gap = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_e = 1'b0;
      ehigh  = 0;
      npulse = 0;
      was01  = 1'b0;
    end else begin
      if (lcd_e) begin
        ehigh++;
        if (!prev_e) begin
          if (npulse == 0) first_cyc = cyc;
          if (was01) clr_gap = cyc - cyc01;
          was01 = (lcd_rs == 1'b0 && lcd_data == 8'h01);
          if (was01) cyc01 = cyc;
          npulse++;
          if (exp_q.size() == 0)
            chk("unexpected_byte", 32'({lcd_rs, lcd_data}), 32'hFFFF_FFFF);
          else
            chk("lcd_byte", 32'({lcd_rs, lcd_data}), 32'(exp_q.pop_front()));
          chk("lcd_rw", 32'(lcd_rw), 32'd0);
        end
      end else if (prev_e) begin
        chk("e_width", 32'(ehigh), 32'd1);
        ehigh = 0;
      end
      prev_e = lcd_e;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!ascii_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!ascii_ready) chk("send_timeout", 32'(ascii_ready), 32'd1);
    ascii_in    = b;
    ascii_valid = 1'b1;
    @(posedge clk); #1;
    ascii_valid = 1'b0;
    model_char(b);
  endtask

  task automatic wait_init(input int rel);
    int n = 0;
    while (!init_done && n < 4000) begin @(negedge clk); n++; end
    chk("init_done", 32'(init_done), 32'd1);
    chk("pwr_wait_window", 32'((first_cyc - rel) inside {[1310:1320]}), 32'd1);
    chk("init_done_after_clear", 32'((cyc - cyc01) inside {[163:170]}), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int rel, acc, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(ascii_ready), 32'd1);

    // Release reset, then burst FIFO_DEPTH+2 bytes during init
    init_expect();
    rel   = cyc;
    rst_n = 1'b1;
    acc   = 0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      ascii_in    = 8'h61 + 8'(i);
      ascii_valid = 1'b1;
      @(posedge clk); #1;
      if (acc < FIFO_DEPTH) begin
        model_char(8'h61 + 8'(i));
        acc++;
      end
      chk("ready_burst", 32'(ascii_ready), 32'(acc < FIFO_DEPTH));
    end
    ascii_valid = 1'b0;
    wait_init(rel);
    wait_drain("drain_burst");

    // Clear, then 33 printable chars to exercise row wrap and full-display wrap
    clr_gap = 0;
    send(8'h0C);
    for (int i = 0; i < 33; i++) send(8'h41 + 8'(i));
    wait_drain("drain_wrap");
    chk("clear_wait_window", 32'(clr_gap inside {[164:175]}), 32'd1);

    // Control codes: FF, X, LF, Y, CR, Z, discards, W
    send(8'h0C); send("X"); send(8'h0A); send("Y");
    send(8'h0D); send("Z"); send(8'h7F); send(8'h01); send("W");
    wait_drain("drain_ctrl");

    // Reset in the middle of an E_HIGH with bytes still queued
    for (int i = 0; i < 6; i++) send(8'h4D + 8'(i));
    n = 0;
    while (!lcd_e && n < 2000) begin @(negedge clk); n++; end
    chk("saw_e_high", 32'(lcd_e), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_lcd_e", 32'(lcd_e), 32'd0);
    chk("midrst_lcd_data", 32'(lcd_data), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_ready", 32'(ascii_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    init_expect();
    rel   = cyc;
    rst_n = 1'b1;
    wait_init(rel);
    wait_drain("drain_after_reset");
    send("Q");
    wait_drain("drain_q");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
